// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: 8 unrolled rounds per clock, 144-edge warm-up, then one byte per read.
// Optional macro TRIVIUM_REKEY_EN adds a synchronous rekey input that restarts initialization.
module trivium_keystream_gen #(
    parameter logic [79:0] KEY = 80'h0,
    parameter logic [79:0] IV  = 80'h0
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef TRIVIUM_REKEY_EN
    input  logic       rekey,
`endif
    input  logic       keystream_read,
    output logic [7:0] keystream_byte,
    output logic       keystream_valid
);

    typedef enum logic [1:0] {
        INIT,
        FILL,
        READY
    } state_e;

    // Bit i of the vector is Trivium state bit s(i+1).
    localparam logic [287:0] SEED      = {3'b111, 112'h0, IV, 13'h0, KEY};
    localparam logic [7:0]   INIT_LAST = 8'd143;

    state_e       fsm_q, fsm_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [287:0] s_q, s_d, s_adv;
    logic [7:0]   byte_q, byte_d, z_adv;
    logic         valid_q, valid_d;
    logic         rekey_s;

`ifdef TRIVIUM_REKEY_EN
    assign rekey_s = rekey;
`else
    assign rekey_s = 1'b0;
`endif

    // Returns {z, next_state} for a single Trivium round.
    function automatic logic [288:0] trivium_round(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90] & s[91]) ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    always_comb begin
        logic [288:0] rnd;
        s_adv = s_q;
        z_adv = '0;
        rnd   = '0;
        for (int i = 0; i < 8; i++) begin
            rnd      = trivium_round(s_adv);
            z_adv[i] = rnd[288];
            s_adv    = rnd[287:0];
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        if (rekey_s) begin
            fsm_d   = INIT;
            cnt_d   = '0;
            s_d     = SEED;
            byte_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (fsm_q)
                INIT: begin
                    s_d = s_adv;
                    if (cnt_q == INIT_LAST) begin
                        fsm_d = FILL;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                FILL: begin
                    s_d     = s_adv;
                    byte_d  = z_adv;
                    valid_d = 1'b1;
                    fsm_d   = READY;
                end
                READY: begin
                    if (keystream_read) begin
                        s_d    = s_adv;
                        byte_d = z_adv;
                    end
                end
                default: begin
                    fsm_d = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= INIT;
            cnt_q   <= '0;
            s_q     <= SEED;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign keystream_byte  = byte_q;
    assign keystream_valid = valid_q;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Directed bench for trivium_keystream_gen against a bit-serial Trivium model.
// A second instance with a non-zero key/IV exercises the key and IV load mapping.
module tb_trivium_keystream_gen;

    localparam logic [79:0] KEY_A = 80'h0;
    localparam logic [79:0] IV_A  = 80'h0;
    localparam logic [79:0] KEY_B = 80'h3C5A_0F1E_D2B4_9687_A5C3;
    localparam logic [79:0] IV_B  = 80'h7E81_1234_FEDC_BA98_0F0F;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] byte_a, byte_b;
    logic       valid_a, valid_b;
`ifdef TRIVIUM_REKEY_EN
    logic       rekey = 1'b0;
`endif

    int         errors = 0;
    int         checks = 0;
    int         idx;
    logic [7:0] exp_a [0:31];
    logic [7:0] exp_b [0:31];
    bit         m [1:288];

    trivium_keystream_gen #(.KEY(KEY_A), .IV(IV_A)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef TRIVIUM_REKEY_EN
        .rekey          (rekey),
`endif
        .keystream_read (rd),
        .keystream_byte (byte_a),
        .keystream_valid(valid_a)
    );

    trivium_keystream_gen #(.KEY(KEY_B), .IV(IV_B)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef TRIVIUM_REKEY_EN
        .rekey          (rekey),
`endif
        .keystream_read (rd),
        .keystream_byte (byte_b),
        .keystream_valid(valid_b)
    );

    initial forever #5 clk = ~clk;

    task automatic model_round(output bit z);
        bit t1, t2, t3;
        t1 = m[66] ^ m[93];
        t2 = m[162] ^ m[177];
        t3 = m[243] ^ m[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (m[91] & m[92]) ^ m[171];
        t2 = t2 ^ (m[175] & m[176]) ^ m[264];
        t3 = t3 ^ (m[286] & m[287]) ^ m[69];
        for (int i = 93; i > 1; i--) m[i] = m[i-1];
        m[1] = t3;
        for (int i = 177; i > 94; i--) m[i] = m[i-1];
        m[94] = t1;
        for (int i = 288; i > 178; i--) m[i] = m[i-1];
        m[178] = t2;
    endtask

    task automatic gen_stream(input logic [79:0] k, input logic [79:0] iv,
                              output logic [7:0] out [0:31]);
        bit         z;
        logic [7:0] b;
        for (int i = 1; i <= 288; i++) m[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            m[i+1]  = k[i];
            m[i+94] = iv[i];
        end
        m[286] = 1'b1;
        m[287] = 1'b1;
        m[288] = 1'b1;
        for (int r = 0; r < 1152; r++) model_round(z);
        for (int n = 0; n < 32; n++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                model_round(z);
                b[j] = z;
            end
            out[n] = b;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_init();
        for (int e = 1; e <= 144; e++) begin
            step();
            check("init_valid", {7'd0, valid_a}, 8'd0);
        end
    endtask

    initial begin
        gen_stream(KEY_A, IV_A, exp_a);
        gen_stream(KEY_B, IV_B, exp_b);

        // Power-on reset, then idle through init.
        #2 rst_n = 1'b0;
        #10;
        check("rst_valid", {7'd0, valid_a}, 8'd0);
        check("rst_byte", byte_a, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        run_init();
        step();
        check("first_valid", {7'd0, valid_a}, 8'd1);
        check("first_byte_a", byte_a, exp_a[0]);
        check("first_byte_b", byte_b, exp_b[0]);
        for (int h = 0; h < 3; h++) begin
            step();
            check("idle_hold", byte_a, exp_a[0]);
            check("idle_valid", {7'd0, valid_a}, 8'd1);
        end

        // Back-to-back reads: one new byte per edge.
        rd = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("burst_byte_a", byte_a, exp_a[k]);
            check("burst_byte_b", byte_b, exp_b[k]);
            check("burst_valid", {7'd0, valid_a}, 8'd1);
        end
        rd = 1'b0;

        // Read pulsed every third cycle.
        idx = 16;
        for (int c = 0; c < 9; c++) begin
            rd = (c % 3 == 0);
            step();
            if (c % 3 == 0) idx++;
            check("pulse_byte", byte_a, exp_a[idx]);
            check("pulse_valid", {7'd0, valid_a}, 8'd1);
        end
        rd = 1'b0;

        // Asynchronous reset mid-operation; read held high through init.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {7'd0, valid_a}, 8'd0);
        check("midrst_byte", byte_a, 8'h00);
        rd = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        run_init();
        step();
        check("rdinit_first_byte", byte_a, exp_a[0]);
        check("rdinit_valid", {7'd0, valid_a}, 8'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("rdinit_read", byte_a, exp_a[k]);
        end
        rd = 1'b0;

        // Reset after five reads (edge 150), then idle re-init.
        #2 rst_n = 1'b0;
        #1;
        check("rst150_valid", {7'd0, valid_a}, 8'd0);
        check("rst150_byte", byte_a, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        run_init();
        step();
        check("rst150_first_byte", byte_a, exp_a[0]);
        check("rst150_first_b", byte_b, exp_b[0]);

`ifdef TRIVIUM_REKEY_EN
        // Rekey wins over a simultaneous read and restarts the full init.
        rd = 1'b1;
        step();
        check("pre_rekey_byte", byte_a, exp_a[1]);
        rekey = 1'b1;
        step();
        rekey = 1'b0;
        rd    = 1'b0;
        check("rekey_valid", {7'd0, valid_a}, 8'd0);
        check("rekey_byte", byte_a, 8'h00);
        for (int e = 1; e < 144; e++) begin
            step();
            check("rekey_init_valid", {7'd0, valid_a}, 8'd0);
        end
        step();
        check("rekey_edge144_valid", {7'd0, valid_a}, 8'd0);
        step();
        check("rekey_first_valid", {7'd0, valid_a}, 8'd1);
        check("rekey_first_byte", byte_a, exp_a[0]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
